// File: rtl/dma_engine.sv
// 32-beat block DMA engine: moves one 1024-bit block over a 32-bit req/ack bus.
// Covers misaligned-address rejection, bus errors and a per-beat watchdog.
module dma_engine #(
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dma_rx_start,
  input  logic [31:0]   dma_rx_address,
  input  logic          dma_tx_start,
  input  logic [31:0]   dma_tx_address,
  input  logic [1023:0] dma_tx_data,
  output logic [1023:0] dma_rx_data,
  output logic          dma_done,
  output logic          dma_idle,
  output logic          dma_error,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_req;
  logic            r_we;
  logic            r_err;
  logic [31:0]     r_addr;
  logic [4:0]      r_beat;
  logic [WW-1:0]   r_wdog;
  logic [1023:0]   r_wbuf;
  logic [1023:0]   r_rbuf;
  logic [1023:0]   r_rx_data;

  logic            w_busy;
  logic            w_acc_rx;
  logic            w_acc_tx;
  logic            w_misal;
  logic            w_ack_ok;
  logic            w_ack_err;
  logic            w_tmo;
  logic            w_last;
  logic            w_abort;
  logic [9:0]      w_lane;

  assign w_busy    = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_acc_rx  = (r_state == S_IDLE) && dma_rx_start;
  assign w_acc_tx  = (r_state == S_IDLE) && dma_tx_start
                     && !dma_rx_start;
  // First busy cycle has r_req low; that is where alignment is judged.
  assign w_misal   = w_busy && !r_req && (r_addr[1:0] != 2'b00);
  assign w_ack_ok  = w_busy && r_req && mem_ack && !mem_err;
  assign w_ack_err = w_busy && r_req && mem_ack && mem_err;
  assign w_tmo     = w_busy && r_req && !mem_ack
                     && (r_wdog == WW'(TIMEOUT - 1));
  assign w_last    = w_ack_ok && (r_beat == 5'd31);
  assign w_abort   = w_misal || w_ack_err || w_tmo;
  assign w_lane    = {r_beat, 5'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (dma_rx_start) begin
          w_next = S_READ;
        end else if (dma_tx_start) begin
          w_next = S_WRITE;
        end
      end
      S_READ, S_WRITE: begin
        if (w_abort || w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dma_idle    = (r_state == S_IDLE);
    dma_done    = (r_state == S_DONE);
    dma_error   = r_err;
    dma_rx_data = r_rx_data;
    mem_req     = r_req;
    mem_we      = r_we;
    mem_addr    = r_addr;
    mem_wdata   = r_wbuf[w_lane +: 32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_wdog    <= '0;
      r_wbuf    <= '0;
      r_rbuf    <= '0;
      r_rx_data <= '0;
    end else begin
      if (w_acc_rx || w_acc_tx) begin
        r_addr <= w_acc_rx ? dma_rx_address : dma_tx_address;
        r_we   <= w_acc_tx;
        r_err  <= 1'b0;
        r_beat <= '0;
        r_wdog <= '0;
      end
      if (w_acc_tx) begin
        r_wbuf <= dma_tx_data;
      end
      if (w_busy && !r_req && !w_misal) begin
        r_req <= 1'b1;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
      if (w_ack_err || w_tmo || w_last) begin
        r_req <= 1'b0;
      end
      if (w_ack_ok) begin
        r_wdog <= '0;
        if (!r_we) begin
          r_rbuf[w_lane +: 32] <= mem_rdata;
        end
        if (!w_last) begin
          r_beat <= r_beat + 5'd1;
          r_addr <= r_addr + 32'd4;
        end
      end else if (w_busy && r_req) begin
        r_wdog <= r_wdog + WW'(1);
      end
      // Publish the block only once every beat has landed cleanly.
      if (w_last && !r_we) begin
        r_rx_data <= {mem_rdata, r_rbuf[991:0]};
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Randomized bench for dma_engine with a behavioural memory responder
// and a block-level reference model.
module tb_dma_engine;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_rx_start;
  logic [31:0]   dma_rx_address;
  logic          dma_tx_start;
  logic [31:0]   dma_tx_address;
  logic [1023:0] dma_tx_data;
  logic [1023:0] dma_rx_data;
  logic          dma_done;
  logic          dma_idle;
  logic          dma_error;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          mem_err;

  dma_engine #(.TIMEOUT(256)) dut (
    .clk(clk),
    .reset(reset),
    .dma_rx_start(dma_rx_start),
    .dma_rx_address(dma_rx_address),
    .dma_tx_start(dma_tx_start),
    .dma_tx_address(dma_tx_address),
    .dma_tx_data(dma_tx_data),
    .dma_rx_data(dma_rx_data),
    .dma_done(dma_done),
    .dma_idle(dma_idle),
    .dma_error(dma_error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pat [0:31];
  logic [31:0] log_addr [0:63];
  logic        log_we [0:63];
  logic [31:0] log_wd [0:63];
  int nbeats = 0;
  int waits = 0;
  int wcnt = 0;
  int err_beat = -1;
  bit ack_en = 1'b1;
  int done_cnt = 0;
  int done_cyc = 0;
  logic req_at_done;
  int cyc = 0;
  int t0 = 0;
  int lat = 0;

  always @(posedge clk) cyc++;

  // Memory: acks after `waits` stall cycles, returns pat[beat].
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      wcnt = 0;
    end else if (!ack_en) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
    end else if (wcnt == waits) begin
      mem_ack = 1'b1;
      wcnt = 0;
      mem_rdata = (nbeats < 32) ? pat[nbeats] : 32'h0;
      mem_err = (nbeats == err_beat);
      if (nbeats < 64) begin
        log_addr[nbeats] = mem_addr;
        log_we[nbeats] = mem_we;
        log_wd[nbeats] = mem_wdata;
      end
      nbeats++;
    end else begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
      req_at_done = mem_req;
    end
  end

  function automatic logic [1023:0] model_block();
    logic [1023:0] b;
    for (int k = 0; k < 32; k++) b[32*k +: 32] = pat[k];
    return b;
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] b;
    for (int k = 0; k < 32; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  task automatic do_xfer(input bit rx, input bit tx,
                         input logic [31:0] ra, input logic [31:0] ta,
                         input logic [1023:0] td, input int w,
                         input int eb, input bit ack_on,
                         input int busy_at);
    waits = w;
    err_beat = eb;
    ack_en = ack_on;
    nbeats = 0;
    done_cnt = 0;
    @(negedge clk);
    t0 = cyc;
    dma_rx_start = rx;
    dma_tx_start = tx;
    dma_rx_address = ra;
    dma_tx_address = ta;
    dma_tx_data = td;
    @(negedge clk);
    dma_rx_start = 1'b0;
    dma_tx_start = 1'b0;
    dma_tx_data = rand_block();
    n_vec++;
    if (dma_idle !== 1'b0 || dma_error !== 1'b0) begin
      $display("FAIL start_ack idle=%b err=%b want 0 0",
               dma_idle, dma_error);
      n_err++;
    end
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      dma_tx_start = (i == busy_at);
      dma_tx_address = 32'h0000_9000;
      @(negedge clk);
    end
    dma_tx_start = 1'b0;
    if (done_cnt == 0) begin
      $display("FAIL done_timeout no dma_done within 2000 cycles");
      n_err++;
    end
    repeat (3) @(negedge clk);
    lat = done_cyc - t0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dma_idle !== 1'b1 || dma_done !== 1'b0 || dma_error !== 1'b0) begin
      $display("FAIL reset_flags idle=%b done=%b err=%b want 1 0 0",
               dma_idle, dma_done, dma_error);
      n_err++;
    end
    n_vec++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0
        || mem_wdata !== 32'h0) begin
      $display("FAIL reset_bus req=%b we=%b addr=%h wd=%h want zeros",
               mem_req, mem_we, mem_addr, mem_wdata);
      n_err++;
    end
    n_vec++;
    if (dma_rx_data !== '0) begin
      $display("FAIL reset_rxdata low=%h want 0", dma_rx_data[31:0]);
      n_err++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [1023:0] exp;
    int bad;
    for (int k = 0; k < 32; k++) pat[k] = 32'hA500_0000 + k;
    do_xfer(1, 0, 32'h1000, 32'h0, '0, 0, -1, 1, -1);
    exp = model_block();
    n_vec++;
    if (lat !== 34) begin
      $display("FAIL read_latency got %0d want 34", lat);
      n_err++;
    end
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (log_addr[k] !== 32'h1000 + 4*k || log_we[k] !== 1'b0) bad++;
    n_vec++;
    if (nbeats !== 32 || bad != 0) begin
      $display("FAIL read_beats got %0d beats %0d bad want 32 0",
               nbeats, bad);
      n_err++;
    end
    n_vec++;
    if (dma_rx_data[31:0] !== 32'hA500_0000
        || dma_rx_data[1023:992] !== 32'hA500_001F) begin
      $display("FAIL read_ends got %h %h want a5000000 a500001f",
               dma_rx_data[31:0], dma_rx_data[1023:992]);
      n_err++;
    end
    n_vec++;
    if (dma_rx_data !== exp) begin
      $display("FAIL read_block got %h want %h",
               dma_rx_data[511:480], exp[511:480]);
      n_err++;
    end
    n_vec++;
    if (done_cnt !== 1 || dma_error !== 1'b0 || req_at_done !== 1'b0) begin
      $display("FAIL read_done cnt=%0d err=%b req=%b want 1 0 0",
               done_cnt, dma_error, req_at_done);
      n_err++;
    end
  endtask

  task automatic test_random_read();
    logic [31:0] base;
    logic [1023:0] exp;
    int w;
    int bad;
    for (int t = 0; t < 4; t++) begin
      base = (t == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFFC);
      w = $urandom_range(0, 2);
      for (int k = 0; k < 32; k++) pat[k] = $urandom;
      do_xfer(1, 0, base, 32'h0, '0, w, -1, 1, -1);
      exp = model_block();
      bad = 0;
      for (int k = 0; k < 32; k++)
        if (log_addr[k] !== base + 32'(4*k)) bad++;
      n_vec++;
      if (nbeats !== 32 || bad != 0 || dma_rx_data !== exp
          || dma_error !== 1'b0 || done_cnt !== 1) begin
        $display("FAIL rand_read base=%h beats=%0d bad=%0d err=%b done=%0d",
                 base, nbeats, bad, dma_error, done_cnt);
        n_err++;
      end
    end
  endtask

  task automatic test_write();
    logic [1023:0] td;
    logic [1023:0] prev;
    logic [31:0] base;
    int bad;
    for (int t = 0; t < 3; t++) begin
      td = (t == 0) ? 1024'h1 : rand_block();
      base = (t == 0) ? 32'h2000 : ($urandom & 32'hFFFF_FFFC);
      prev = dma_rx_data;
      do_xfer(0, 1, 32'h0, base, td, (t == 0) ? 3 : t, -1, 1, -1);
      bad = 0;
      for (int k = 0; k < 32; k++)
        if (log_we[k] !== 1'b1 || log_wd[k] !== td[32*k +: 32]
            || log_addr[k] !== base + 32'(4*k)) bad++;
      n_vec++;
      if (nbeats !== 32 || bad != 0) begin
        $display("FAIL write_beats t=%0d beats=%0d bad=%0d want 32 0",
                 t, nbeats, bad);
        n_err++;
      end
      n_vec++;
      if (done_cnt !== 1 || dma_error !== 1'b0 || dma_rx_data !== prev) begin
        $display("FAIL write_done t=%0d cnt=%0d err=%b rx_kept=%b",
                 t, done_cnt, dma_error, dma_rx_data === prev);
        n_err++;
      end
    end
  endtask

  task automatic test_misaligned();
    do_xfer(1, 0, 32'h1002, 32'h0, '0, 0, -1, 1, -1);
    n_vec++;
    if (lat !== 2 || nbeats !== 0 || dma_error !== 1'b1
        || done_cnt !== 1) begin
      $display("FAIL misalign lat=%0d beats=%0d err=%b done=%0d want 2 0 1 1",
               lat, nbeats, dma_error, done_cnt);
      n_err++;
    end
    for (int k = 0; k < 32; k++) pat[k] = $urandom;
    do_xfer(1, 0, 32'h1000, 32'h0, '0, 0, -1, 1, -1);
    n_vec++;
    if (dma_error !== 1'b0 || nbeats !== 32) begin
      $display("FAIL misalign_clear err=%b beats=%0d want 0 32",
               dma_error, nbeats);
      n_err++;
    end
  endtask

  task automatic test_bus_error();
    logic [1023:0] prev;
    prev = dma_rx_data;
    for (int k = 0; k < 32; k++) pat[k] = $urandom;
    do_xfer(1, 0, 32'h4000, 32'h0, '0, $urandom_range(0, 1), 5, 1, -1);
    n_vec++;
    if (nbeats !== 6 || req_at_done !== 1'b0 || done_cnt !== 1) begin
      $display("FAIL buserr_stop beats=%0d req=%b done=%0d want 6 0 1",
               nbeats, req_at_done, done_cnt);
      n_err++;
    end
    n_vec++;
    if (dma_error !== 1'b1 || dma_rx_data !== prev) begin
      $display("FAIL buserr_state err=%b rx_kept=%b want 1 1",
               dma_error, dma_rx_data === prev);
      n_err++;
    end
  endtask

  task automatic test_timeout();
    do_xfer(1, 0, 32'h5000, 32'h0, '0, 0, -1, 0, -1);
    ack_en = 1'b1;
    n_vec++;
    if (lat !== 258 || dma_error !== 1'b1 || done_cnt !== 1
        || req_at_done !== 1'b0) begin
      $display("FAIL timeout lat=%0d err=%b done=%0d req=%b want 258 1 1 0",
               lat, dma_error, done_cnt, req_at_done);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 32; k++) pat[k] = $urandom;
    waits = 0;
    err_beat = -1;
    ack_en = 1'b1;
    nbeats = 0;
    done_cnt = 0;
    @(negedge clk);
    dma_rx_start = 1'b1;
    dma_rx_address = 32'h3000;
    @(negedge clk);
    dma_rx_start = 1'b0;
    for (int i = 0; i < 200 && nbeats < 10; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dma_idle !== 1'b1 || mem_req !== 1'b0 || dma_rx_data !== '0) begin
      $display("FAIL reset_mid idle=%b req=%b want 1 0", dma_idle, mem_req);
      n_err++;
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (done_cnt !== 0 || dma_idle !== 1'b1) begin
      $display("FAIL reset_mid_done cnt=%0d idle=%b want 0 1",
               done_cnt, dma_idle);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int k = 0; k < 32; k++) pat[k] = $urandom;
    do_xfer(1, 1, 32'h6000, 32'h7000, rand_block(), 0, -1, 1, -1);
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (log_we[k] !== 1'b0 || log_addr[k] !== 32'h6000 + 4*k) bad++;
    n_vec++;
    if (nbeats !== 32 || bad != 0 || dma_rx_data !== model_block()) begin
      $display("FAIL both_starts beats=%0d bad=%0d want 32 0", nbeats, bad);
      n_err++;
    end
    for (int k = 0; k < 32; k++) pat[k] = $urandom;
    do_xfer(1, 0, 32'h8000, 32'h0, '0, 1, -1, 1, 10);
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (log_we[k] !== 1'b0) bad++;
    n_vec++;
    if (nbeats !== 32 || bad != 0 || done_cnt !== 1 || dma_idle !== 1'b1
        || dma_rx_data !== model_block()) begin
      $display("FAIL busy_start beats=%0d bad=%0d done=%0d idle=%b",
               nbeats, bad, done_cnt, dma_idle);
      n_err++;
    end
  endtask

  initial begin
    reset = 1'b1;
    dma_rx_start = 1'b0;
    dma_tx_start = 1'b0;
    dma_rx_address = '0;
    dma_tx_address = '0;
    dma_tx_data = '0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_rdata = '0;
    for (int k = 0; k < 32; k++) pat[k] = '0;
    test_reset();
    test_read();
    test_random_read();
    test_write();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
